// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
//   state_e  - sequencer states (IDLE / ACCESS / RESP)
//   port_t   - requester index (0 = core LSU, 1 = DMA/debug loader)
//   F3_*     - RISC-V funct3 encodings for the load/store widths
//   acc_t    - access register captured at grant time
//   misaligned() - natural-alignment test used when DMEM_ARB_ALIGN_CHECK_EN is defined
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic port_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Field widths of the access register; the top-level parameters default
  // to these, and the top casts when they are overridden.
  localparam int ACC_ADDR_W = 32;
  localparam int ACC_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [2:0]            func3;
    logic [ACC_ADDR_W-1:0] addr;
    logic [ACC_DATA_W-1:0] wdata;
    port_t                 port;
  } acc_t;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes and the
  // undefined encodings are never flagged.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = a[0];
      F3_W:        bad = |a;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin pick.
//   req  - per-port request
//   last - port granted most recently
//   gnt  - one-hot grant vector (all zero when nobody requests)
//   win  - index of the winning port (0 when nobody requests)
// A lone requester always wins; with both requesting, the port that did not
// win last time is chosen.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  output logic [1:0] gnt,
  output port_t      win
);

  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    case (req)
      2'b01: begin gnt = 2'b01; win = 1'b0; end
      2'b10: begin gnt = 2'b10; win = 1'b1; end
      2'b11: begin
        win = ~last;
        gnt = last ? 2'b01 : 2'b10;
      end
      default: begin gnt = 2'b00; win = 1'b0; end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the byte-addressed
// data memory. One access per slot: grant (IDLE/RESP) -> ACCESS -> RESP.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_i/we_i/func3_i/addr_i/wdata_i - per-port request fields (index = port)
//   gnt_o                   - combinational one-hot grant; fields captured this cycle
//   done_o                  - registered one-cycle completion pulse
//   rdata_o, err_o          - registered load data / misalignment flag, valid with done_o
//   mem_we/func3/addr/wdata - memory command, active only in ACCESS
//   mem_rdata               - combinational memory read data
//
// Handshake: a port holds req_i until it sees gnt_o in the same cycle; the
// request fields are sampled at that clock edge and may change afterwards.
// Dropping req_i before gnt_o has no effect.
//
// Build option DMEM_ARB_ALIGN_CHECK_EN: misaligned halfword/word accesses are
// blocked from writing memory and complete with err_o=1, rdata_o=0. Without it
// err_o is tied 0 and every access reaches memory unchanged.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ACC_ADDR_W,
  parameter int DATA_WIDTH = ACC_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][2:0]            func3_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 done_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       err_o,
  output logic                       mem_we,
  output logic [2:0]                 mem_func3,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  state_e                state_q, state_d;
  port_t                 last_q;
  acc_t                  acc_q;
  logic [1:0]            done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            pick_gnt;
  port_t                 pick_win;
  logic                  grant;
  logic                  acc_bad;

  dmem_rr_pick u_pick (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .win  (pick_win)
  );

  // Grants are only offered while the memory slot is free; gating with rst_n
  // keeps gnt_o low while reset is held.
  always_comb begin
    gnt_o = 2'b00;
    if (rst_n && (state_q != ACCESS)) gnt_o = pick_gnt;
  end

  assign grant = |gnt_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = grant ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign acc_bad = misaligned(acc_q.func3, acc_q.addr[1:0]);
  assign err_o   = err_q;
`else
  assign acc_bad = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Command fields hold the last captured access; only the write strobe is
  // qualified by the state, so reset during ACCESS kills it at once.
  assign mem_we    = (state_q == ACCESS) && acc_q.we && !acc_bad;
  assign mem_func3 = acc_q.func3;
  assign mem_addr  = ADDR_WIDTH'(acc_q.addr);
  assign mem_wdata = DATA_WIDTH'(acc_q.wdata);
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      acc_q   <= '0;
      done_q  <= 2'b00;
      rdata_q <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 2'b00;
      if (grant) begin
        last_q      <= pick_win;
        acc_q.we    <= we_i[pick_win];
        acc_q.func3 <= func3_i[pick_win];
        acc_q.addr  <= ACC_ADDR_W'(addr_i[pick_win]);
        acc_q.wdata <= ACC_DATA_W'(wdata_i[pick_win]);
        acc_q.port  <= pick_win;
      end
      if (state_q == ACCESS) begin
        done_q[acc_q.port] <= 1'b1;
        // Stores and blocked accesses report zero data.
        rdata_q <= (acc_q.we || acc_bad) ? '0 : mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        err_q   <= acc_bad;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a
// byte-addressed memory model behind the mem_* port. Each table row is one
// clock cycle: inputs applied on the falling edge, outputs compared 1 ns later.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [1:0]       req_i, we_i, gnt_o, done_o;
  logic [1:0][2:0]  func3_i;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [31:0]      rdata_o, mem_addr, mem_wdata, mem_rdata;
  logic             err_o, mem_we;
  logic [2:0]       mem_func3;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .we_i      (we_i),
    .func3_i   (func3_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .mem_we    (mem_we),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- memory model (256 bytes, low address bits) ----------------
  logic [7:0] mem [0:255];
  logic       mem_init_done = 1'b0;
  logic [7:0] rd_a;
  logic [7:0] b0, b1, b2, b3;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20] <= 8'h0D;
      mem[8'h21] <= 8'hF0;
      mem[8'h22] <= 8'hFE;
      mem[8'h23] <= 8'hCA;
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      case (mem_func3)
        3'd0: mem[mem_addr[7:0]] <= mem_wdata[7:0];
        3'd1: begin
          mem[mem_addr[7:0]]         <= mem_wdata[7:0];
          mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
        end
        default: begin
          mem[mem_addr[7:0]]         <= mem_wdata[7:0];
          mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
          mem[mem_addr[7:0] + 8'd2]  <= mem_wdata[23:16];
          mem[mem_addr[7:0] + 8'd3]  <= mem_wdata[31:24];
        end
      endcase
    end
  end

  always_comb begin
    rd_a = mem_addr[7:0];
    b0 = mem[rd_a];
    b1 = mem[rd_a + 8'd1];
    b2 = mem[rd_a + 8'd2];
    b3 = mem[rd_a + 8'd3];
    mem_rdata = 32'h0;
    case (mem_func3)
      3'd0: mem_rdata = {{24{b0[7]}}, b0};
      3'd1: mem_rdata = {{16{b1[7]}}, b1, b0};
      3'd2: mem_rdata = {b3, b2, b1, b0};
      3'd4: mem_rdata = {24'h0, b0};
      3'd5: mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  // ---------------- build-dependent expectations ----------------
  // SH 0xBEEF to 0x10001 is misaligned: with the check it is blocked,
  // otherwise it overwrites bytes 1..2 of the word at 0x10000 (0x80ADBEEF).
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam logic        MIS_ERR     = 1'b1;
  localparam logic        MIS_WE      = 1'b0;
  localparam logic [31:0] WORD0_FINAL = 32'h80AD_BEEF;
`else
  localparam logic        MIS_ERR     = 1'b0;
  localparam logic        MIS_WE      = 1'b1;
  localparam logic [31:0] WORD0_FINAL = 32'h80BE_EFEF;
`endif

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_done;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [1:0] req, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] e_gnt, input logic [1:0] e_done,
                              input logic e_we, input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.req = req; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.e_gnt = e_gnt; v.e_done = e_done; v.e_we = e_we; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_both(input logic [1:0] req, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    req_i = req;
    for (int p = 0; p < 2; p++) begin
      we_i[p]    = we;
      func3_i[p] = f3;
      addr_i[p]  = addr;
      wdata_i[p] = wdata;
    end
  endtask

  task automatic idle_inputs();
    drive_both(2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);

    // Reset: requests present but nothing may be granted; outputs all zero.
    @(negedge clk);
    drive_both(2'b11, 1'b1, 3'd2, 32'h0001_0000, 32'h1234_5678);
    #1;
    chk("rst gnt",       32'(gnt_o),     32'h0);
    chk("rst done",      32'(done_o),    32'h0);
    chk("rst rdata",     rdata_o,        32'h0);
    chk("rst err",       32'(err_o),     32'h0);
    chk("rst mem_we",    32'(mem_we),    32'h0);
    chk("rst mem_func3", 32'(mem_func3), 32'h0);
    chk("rst mem_addr",  mem_addr,       32'h0);
    chk("rst mem_wdata", mem_wdata,      32'h0);
    idle_inputs();
    rst_n = 1'b1;

    //                req    we    f3    addr          wdata         gnt    done   we      rdata          err
    tbl[0]  = mk(2'b01, 1'b1, 3'd2, 32'h0001_0000, 32'hDEAD_BEEF, 2'b01, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[1]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b1,   32'h0,         1'b0);
    tbl[2]  = mk(2'b01, 1'b0, 3'd2, 32'h0001_0000, 32'h0,         2'b01, 2'b01, 1'b0,   32'h0,         1'b0);
    tbl[3]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[4]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b01, 1'b0,   32'hDEAD_BEEF, 1'b0);
    tbl[5]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[6]  = mk(2'b10, 1'b1, 3'd0, 32'h0001_0003, 32'h0000_0080, 2'b10, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[7]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b1,   32'h0,         1'b0);
    tbl[8]  = mk(2'b01, 1'b0, 3'd0, 32'h0001_0003, 32'h0,         2'b01, 2'b10, 1'b0,   32'h0,         1'b0);
    tbl[9]  = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[10] = mk(2'b01, 1'b0, 3'd4, 32'h0001_0003, 32'h0,         2'b01, 2'b01, 1'b0,   32'hFFFF_FF80, 1'b0);
    tbl[11] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[12] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b01, 1'b0,   32'h0000_0080, 1'b0);
    tbl[13] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    // Port 0 pulses a store request while port 1 owns ACCESS, then drops it.
    tbl[14] = mk(2'b10, 1'b0, 3'd2, 32'h0001_0000, 32'h0,         2'b10, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[15] = mk(2'b01, 1'b1, 3'd2, 32'h0001_0000, 32'h1111_1111, 2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[16] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b10, 1'b0,   32'h80AD_BEEF, 1'b0);
    tbl[17] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[18] = mk(2'b01, 1'b0, 3'd2, 32'h0001_0000, 32'h0,         2'b01, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[19] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[20] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b01, 1'b0,   32'h80AD_BEEF, 1'b0);
    // Misaligned SH, then a LW issued in the RESP cycle of that SH.
    tbl[21] = mk(2'b01, 1'b1, 3'd1, 32'h0001_0001, 32'h0000_BEEF, 2'b01, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[22] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, MIS_WE, 32'h0,         1'b0);
    tbl[23] = mk(2'b01, 1'b0, 3'd2, 32'h0001_0000, 32'h0,         2'b01, 2'b01, 1'b0,   32'h0,         MIS_ERR);
    tbl[24] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);
    tbl[25] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b01, 1'b0,   WORD0_FINAL,   1'b0);
    tbl[26] = mk(2'b00, 1'b0, 3'd0, 32'h0,         32'h0,         2'b00, 2'b00, 1'b0,   32'h0,         1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_both(tbl[i].req, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
      #1;
      chk($sformatf("v%0d gnt", i),    32'(gnt_o),  32'(tbl[i].e_gnt));
      chk($sformatf("v%0d done", i),   32'(done_o), 32'(tbl[i].e_done));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      if (tbl[i].e_done != 2'b00) begin
        chk($sformatf("v%0d rdata", i), rdata_o,     tbl[i].e_rdata);
        chk($sformatf("v%0d err", i),   32'(err_o),  32'(tbl[i].e_err));
      end
    end

    // Reset during ACCESS of SW 0x12345678 -> 0x10020: no commit, no done.
    @(negedge clk);
    drive_both(2'b01, 1'b1, 3'd2, 32'h0001_0020, 32'h1234_5678);
    #1;
    chk("rma gnt", 32'(gnt_o), 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rma mem_we before", 32'(mem_we), 32'h1);
    chk("rma mem_addr",      mem_addr,    32'h0001_0020);
    chk("rma mem_wdata",     mem_wdata,   32'h1234_5678);
    rst_n = 1'b0;
    #1;
    chk("rma mem_we after",  32'(mem_we), 32'h0);
    chk("rma mem_addr rst",  mem_addr,    32'h0);
    @(negedge clk);
    #1;
    chk("rma done", 32'(done_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    drive_both(2'b01, 1'b0, 3'd2, 32'h0001_0020, 32'h0);
    #1;
    chk("rma ld gnt", 32'(gnt_o), 32'h1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rma ld done",  32'(done_o), 32'h1);
    chk("rma ld rdata", rdata_o,     32'hCAFE_F00D);

    // Fresh reset, then both ports hold loads: grants 0,1,0,1 every other cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] eg, ed;
      @(negedge clk);
      req_i      = (k < 8) ? 2'b11 : 2'b00;
      we_i       = 2'b00;
      func3_i[0] = 3'd2;  addr_i[0] = 32'h0001_0000;  wdata_i[0] = 32'h0;
      func3_i[1] = 3'd2;  addr_i[1] = 32'h0001_0020;  wdata_i[1] = 32'h0;
      #1;
      eg = 2'b00;
      if (k < 8 && (k % 4) == 0) eg = 2'b01;
      if (k < 8 && (k % 4) == 2) eg = 2'b10;
      ed = 2'b00;
      if (k == 2 || k == 6) ed = 2'b01;
      if (k == 4 || k == 8) ed = 2'b10;
      chk($sformatf("rr%0d gnt", k),  32'(gnt_o),  32'(eg));
      chk($sformatf("rr%0d done", k), 32'(done_o), 32'(ed));
      if (ed != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("rr%0d queue", k), 32'(exp_q.size()), 32'h1);
        end else begin
          chk($sformatf("rr%0d rdata", k), rdata_o, exp_q.pop_front());
        end
      end
      if (eg == 2'b01) exp_q.push_back(WORD0_FINAL);
      if (eg == 2'b10) exp_q.push_back(32'hCAFE_F00D);
    end
    chk("rr queue empty", 32'(exp_q.size()), 32'h0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
